// File: rtl/cim_wl_seq.sv
`timescale 1ns/1ps
// cim_wl_seq: two-port round-robin arbiter and word-line sequencer for the
// CIM macro. Each granted burst walks a linear 7-bit {bank,row} address and
// emits one registered, break-before-make pulse on cs/wa0 per row.
// Optional feature: define CIM_WL_BCAST_EN to enable broadcast bursts
// (all banks selected, row-only increment).
module cim_wl_seq #(
    parameter int PW  = 2,
    parameter int GAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [6:0]  req0_addr,
    input  logic [6:0]  req0_len,
    input  logic        req0_bcast,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [6:0]  req1_addr,
    input  logic [6:0]  req1_len,
    input  logic        req1_bcast,
    input  logic        abort,
    output logic [15:0] cs,
    output logic [7:0]  wa0,
    output logic        busy,
    output logic        grant_id,
    output logic        done
);
    localparam int TMAX  = (PW > GAP) ? PW : GAP;
    localparam int CNT_W = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [CNT_W-1:0] PW_LAST  = CNT_W'(PW - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [6:0]       addr_q, addr_d;
    logic [6:0]       rem_q, rem_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             abort_q, abort_d;
    logic             prio_q, prio_d;
    logic             gid_q, gid_d;
    logic [15:0]      cs_q, cs_d;
    logic [7:0]       wa_q, wa_d;
    logic             done_q, done_d;

    logic             win;
    logic             hs;
    logic [6:0]       addr_inc;
    logic [15:0]      cs_pulse;

    // Arbitration: a lone requester wins; on contention the round-robin pointer decides
    always_comb begin
        win        = (req0_valid && req1_valid) ? prio_q : req1_valid;
        req0_ready = (state_q == S_IDLE) && req0_valid && !win;
        req1_ready = (state_q == S_IDLE) && req1_valid && win;
        hs         = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    end

`ifdef CIM_WL_BCAST_EN
    logic bc_q;

    // Broadcast flag is captured at the handshake, like the rest of the request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_q <= 1'b0;
        end else if (hs) begin
            bc_q <= win ? req1_bcast : req0_bcast;
        end
    end

    // Broadcast bursts walk only the row field and light every bank
    assign addr_inc = bc_q ? {addr_q[6:3], addr_q[2:0] + 3'd1} : addr_q + 7'd1;
    assign cs_pulse = bc_q ? 16'hFFFF : (16'd1 << addr_d[6:3]);
`else
    logic unused_bcast;
    assign unused_bcast = req0_bcast ^ req1_bcast;
    assign addr_inc     = addr_q + 7'd1;
    assign cs_pulse     = 16'd1 << addr_d[6:3];
`endif

    // State and burst context registers; outputs registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            tcnt_q  <= '0;
            abort_q <= 1'b0;
            prio_q  <= 1'b0;
            gid_q   <= 1'b0;
            cs_q    <= '0;
            wa_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            tcnt_q  <= tcnt_d;
            abort_q <= abort_d;
            prio_q  <= prio_d;
            gid_q   <= gid_d;
            cs_q    <= cs_d;
            wa_q    <= wa_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: SETUP -> (PULSE -> GAP)* -> DONE, with abort draining the current row
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        tcnt_d  = tcnt_q;
        abort_d = abort_q;
        prio_d  = prio_q;
        gid_d   = gid_q;
        case (state_q)
            S_IDLE: begin
                if (hs) begin
                    addr_d  = win ? req1_addr : req0_addr;
                    rem_d   = win ? req1_len : req0_len;
                    gid_d   = win;
                    prio_d  = ~win;
                    abort_d = 1'b0;
                    tcnt_d  = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                tcnt_d  = '0;
                state_d = abort ? S_DONE : S_PULSE;
            end
            S_PULSE: begin
                if (abort) abort_d = 1'b1;
                if (tcnt_q == PW_LAST) begin
                    tcnt_d  = '0;
                    state_d = S_GAP;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (abort) abort_d = 1'b1;
                if (tcnt_q == GAP_LAST) begin
                    tcnt_d = '0;
                    if (rem_q != 7'd0 && !abort_d) begin
                        rem_d   = rem_q - 7'd1;
                        addr_d  = addr_inc;
                        state_d = S_PULSE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: drivers are nonzero only while the next state is PULSE
    always_comb begin
        cs_d   = '0;
        wa_d   = '0;
        done_d = (state_d == S_DONE);
        if (state_d == S_PULSE) begin
            cs_d = cs_pulse;
            wa_d = 8'd1 << addr_d[2:0];
        end
    end

    assign cs       = cs_q;
    assign wa0      = wa_q;
    assign done     = done_q;
    assign grant_id = gid_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_cim_wl_seq.sv
`timescale 1ns/1ps
// Testbench for cim_wl_seq: directed and randomized bursts checked against a
// cycle-offset timeline model derived from the burst parameters.
module tb_cim_wl_seq;
    localparam int PW  = 2;
    localparam int GAP = 1;
    localparam int PER = PW + GAP;
`ifdef CIM_WL_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_bcast;
    logic [6:0]  req0_addr, req0_len;
    logic        req1_valid, req1_ready, req1_bcast;
    logic [6:0]  req1_addr, req1_len;
    logic        abort;
    logic [15:0] cs;
    logic [7:0]  wa0;
    logic        busy, grant_id, done;

    int checks = 0;
    int errors = 0;

    cim_wl_seq #(.PW(PW), .GAP(GAP)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_len(req0_len), .req0_bcast(req0_bcast),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_len(req1_len), .req1_bcast(req1_bcast),
        .abort(abort), .cs(cs), .wa0(wa0), .busy(busy), .grant_id(grant_id), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one burst from an idle DUT and checks every cycle up to the IDLE cycle after done.
    // abort_t: cycle offset after the handshake edge at which abort is pulsed
    // (0 = held during the request in IDLE, -1 = never).
    task automatic run_burst(input int port, input logic [6:0] a, input logic [6:0] l,
                             input logic bc, input int abort_t, output int waited);
        int n, neff, tdone, u, row, ad;
        logic bce;
        logic [15:0] ecs;
        logic [7:0] ewa;
        logic edone, ebusy, rdy;
        bce  = BCAST ? bc : 1'b0;
        n    = int'(l) + 1;
        neff = n;
        if (abort_t == 1) neff = 0;
        else if (abort_t >= 2 && ((abort_t - 2) / PER) + 1 < neff) neff = ((abort_t - 2) / PER) + 1;
        tdone = 2 + neff * PER;
        if (port == 0) begin
            req0_valid = 1'b1; req0_addr = a; req0_len = l; req0_bcast = bc;
        end else begin
            req1_valid = 1'b1; req1_addr = a; req1_len = l; req1_bcast = bc;
        end
        abort  = (abort_t == 0);
        waited = 0;
        #1;
        rdy = (port == 0) ? req0_ready : req1_ready;
        while (!rdy && waited < 50) begin
            @(posedge clk); #1;
            waited++;
            rdy = (port == 0) ? req0_ready : req1_ready;
        end
        if (!rdy) begin
            checks++; errors++;
            $display("FAIL handshake port%0d: ready never rose (got 0, required 1)", port);
            req0_valid = 1'b0; req1_valid = 1'b0; abort = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0; abort = 1'b0;
        req0_addr = 7'($urandom); req0_len = 7'($urandom); req0_bcast = 1'($urandom);
        req1_addr = 7'($urandom); req1_len = 7'($urandom); req1_bcast = 1'($urandom);
        for (int t = 1; t <= tdone + 1; t++) begin
            abort = (t == abort_t);
            ecs = '0; ewa = '0;
            edone = (t == tdone);
            ebusy = (t <= tdone);
            if (t >= 2 && t < tdone) begin
                u   = t - 2;
                row = u / PER;
                if (u % PER < PW) begin
                    if (bce) ad = (int'(a) / 8) * 8 + ((int'(a) % 8) + row) % 8;
                    else     ad = (int'(a) + row) % 128;
                    ecs = bce ? 16'hFFFF : 16'(1 << (ad / 8));
                    ewa = 8'(1 << (ad % 8));
                end
            end
            checks++;
            if (cs !== ecs) begin
                errors++;
                $display("FAIL cs t=%0d addr=%h: got %h required %h", t, a, cs, ecs);
            end
            checks++;
            if (wa0 !== ewa) begin
                errors++;
                $display("FAIL wa0 t=%0d addr=%h: got %h required %h", t, a, wa0, ewa);
            end
            checks++;
            if (done !== edone) begin
                errors++;
                $display("FAIL done t=%0d: got %b required %b", t, done, edone);
            end
            checks++;
            if (busy !== ebusy) begin
                errors++;
                $display("FAIL busy t=%0d: got %b required %b", t, busy, ebusy);
            end
            checks++;
            if (grant_id !== 1'(port)) begin
                errors++;
                $display("FAIL grant_id t=%0d: got %b required %0d", t, grant_id, port);
            end
            if (t <= tdone) begin
                @(posedge clk); #1;
            end
        end
        abort = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL wait_idle: busy stuck (got 1, required 0)");
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (cs !== 16'h0)     begin errors++; $display("FAIL reset_cs: got %h required 0000", cs); end
        checks++; if (wa0 !== 8'h0)     begin errors++; $display("FAIL reset_wa0: got %h required 00", wa0); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (grant_id !== 1'b0) begin errors++; $display("FAIL reset_gid: got %b required 0", grant_id); end
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy0: got %b required 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_rdy1: got %b required 0", req1_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b required 0", busy); end
    endtask

    task automatic test_single();
        int w;
        run_burst(0, 7'h0E, 7'd2, 1'b0, -1, w);
    endtask

    task automatic test_wrap();
        int w;
        run_burst(1, 7'h7F, 7'd1, 1'b0, -1, w);
    endtask

    task automatic test_bcast();
        int w;
        run_burst(0, 7'h25, 7'd2, 1'b1, -1, w);
    endtask

    task automatic test_abort();
        int w;
        run_burst(0, 7'h10, 7'd3, 1'b0, 3, w);   // second cycle of pulse 1
        run_burst(1, 7'h42, 7'd3, 1'b0, 1, w);   // during SETUP: no pulse at all
        run_burst(0, 7'h31, 7'd2, 1'b0, 4, w);   // during the first GAP
        run_burst(1, 7'h05, 7'd1, 1'b0, 0, w);   // in IDLE: ignored
    endtask

    task automatic test_back_to_back();
        int w;
        run_burst(0, 7'h03, 7'd0, 1'b0, -1, w);
        run_burst(1, 7'h64, 7'd1, 1'b0, -1, w);
        checks++;
        if (w !== 0) begin errors++; $display("FAIL b2b_wait: got %0d idle cycles required 0", w); end
        run_burst(0, 7'h1A, 7'd0, 1'b0, -1, w);
        checks++;
        if (w !== 0) begin errors++; $display("FAIL b2b_wait2: got %0d idle cycles required 0", w); end
    endtask

    task automatic test_random();
        int w, p, ab, n;
        logic [6:0] a, l;
        logic bc;
        for (int i = 0; i < 10; i++) begin
            p  = int'($urandom_range(0, 1));
            a  = 7'($urandom);
            l  = 7'($urandom_range(0, 4));
            bc = 1'($urandom);
            n  = int'(l) + 1;
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 1 + n * PER)) : -1;
            run_burst(p, a, l, bc, ab, w);
        end
    endtask

    task automatic test_arb();
        int ex, nh, pend;
        do_reset();
        req0_addr = 7'h11; req0_len = 7'd0; req0_bcast = 1'b0;
        req1_addr = 7'h22; req1_len = 7'd0; req1_bcast = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        ex = 0; nh = 0; pend = -1;
        for (int c = 0; c < 200 && nh < 4; c++) begin
            if (pend >= 0) begin
                checks++;
                if (grant_id !== 1'(pend)) begin errors++; $display("FAIL arb_gid: got %b required %0d", grant_id, pend); end
                pend = -1;
            end
            if (!busy) begin
                checks++;
                if (req0_ready !== (ex == 0)) begin errors++; $display("FAIL arb_rdy0 grant%0d: got %b required %b", nh, req0_ready, ex == 0); end
                checks++;
                if (req1_ready !== (ex == 1)) begin errors++; $display("FAIL arb_rdy1 grant%0d: got %b required %b", nh, req1_ready, ex == 1); end
                pend = ex; ex = 1 - ex; nh++;
            end else begin
                checks++;
                if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                    errors++; $display("FAIL arb_rdy_busy: got %b%b required 00", req0_ready, req1_ready);
                end
            end
            @(posedge clk); #1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (pend < 0 || grant_id !== 1'(pend)) begin errors++; $display("FAIL arb_last_gid: got %b required %0d", grant_id, pend); end
        checks++;
        if (nh != 4) begin errors++; $display("FAIL arb_count: got %0d grants required 4", nh); end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        req0_addr = 7'h33; req0_len = 7'd3; req0_bcast = 1'b0; req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b required 1", req0_ready); end
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (cs !== 16'h0040 || wa0 !== 8'h08) begin errors++; $display("FAIL rm_pulse: got %h/%h required 0040/08", cs, wa0); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (cs !== 16'h0 || wa0 !== 8'h0) begin errors++; $display("FAIL rm_async_clear: got %h/%h required 0000/00", cs, wa0); end
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rm_idle c%0d: busy/done got %b%b required 00", i, busy, done); end
        end
        req0_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin errors++; $display("FAIL rm_ready_after: got %b%b required 10", req0_ready, req1_ready); end
        req0_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rm_no_hs: busy got %b required 0", busy); end
    endtask

    initial begin
        rst_n = 1'b0; abort = 1'b0;
        req0_valid = 1'b0; req0_addr = '0; req0_len = '0; req0_bcast = 1'b0;
        req1_valid = 1'b0; req1_addr = '0; req1_len = '0; req1_bcast = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_bcast();
        test_abort();
        test_back_to_back();
        test_random();
        test_arb();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cim_wl_seq.md
# cim_wl_seq

Word-line sequencer and arbiter for the CIM macro's chip-select/word-line driver. Two requesters share it: port 0 is the weight loader, port 1 is the compute scanner. Each granted burst walks a linear 7-bit row address (4-bit bank, 3-bit row). For every row it produces one registered, break-before-make pulse on the 16-bit bank select `cs` and the 8-bit one-hot row vector `wa0`, which feed the driver directly.

## Interface
- `PW`, 2: pulse width in cycles, legal range ≥1.
- `GAP`, 1: idle cycles between pulses, legal range ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `req0_valid` in 1: port 0 request.
- `req0_ready` out 1: port 0 accept.
- `req0_addr` in 7: start address {bank[6:3], row[2:0]}.
- `req0_len` in 7: row count minus 1 (1..128 rows).
- `req0_bcast` in 1: broadcast request.
- `req1_valid`, `req1_ready`, `req1_addr`, `req1_len`, `req1_bcast`: same meanings for port 1.
- `abort` in 1: terminate the active burst.
- `cs` out 16: bank select, registered.
- `wa0` out 8: one-hot row select, registered.
- `busy` out 1: high in any state other than IDLE.
- `grant_id` out 1: port owning the current or last burst.
- `done` out 1: one-cycle end-of-burst strobe.

## Operation
- States are IDLE, SETUP, PULSE, GAP and DONE.
- Reset values: state=IDLE; cs=0; wa0=0; busy=0; done=0; grant_id=0; both readies=0; round-robin pointer favours port 0.
- IDLE
  - The ready of the arbitration winner is high; the loser's ready is low.
  - If only one port is valid, that port wins.
  - If both ports are valid, the port not granted last wins.
  - On a handshake (valid & ready) the block latches addr, len and bcast, sets grant_id and the RR pointer, and goes to SETUP.
- SETUP: one cycle with cs=0, then PULSE.
- PULSE: lasts PW cycles.
  - cs = one-hot(addr[6:3]).
  - wa0 = one-hot(addr[2:0]).
- GAP: lasts GAP cycles with cs=0 and wa0=0.
  - If rows remain: addr increments modulo 128 (127→0), remaining count decrements, return to PULSE.
  - If no rows remain: go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- cs and wa0 are never nonzero outside PULSE. Consecutive pulses are always separated by at least one all-zero cycle.
- Abort
  - Abort in SETUP goes straight to DONE with no pulse.
  - Abort in PULSE or GAP finishes the current pulse and its GAP, then goes to DONE; no further rows.
  - Abort in IDLE or DONE is ignored.
- Reset mid-burst clears cs and wa0 immediately (asynchronously); the burst is lost and no done strobe is issued.

## Timing
- A handshake on rising edge k puts the block in SETUP for cycle k+1.
- The first pulse occupies cycles k+2 .. k+1+PW.
- An N-row burst asserts done in cycle k+2+N·(PW+GAP).
- The next handshake can occur at the earliest in the cycle after done.
- Readies are combinational from the state and valids only; valid must not depend on ready.
- Requester inputs are sampled only at the handshake; later changes to them have no effect.

## Configuration
- `CIM_WL_BCAST_EN` defined:
  - A burst latched with bcast=1 drives cs=16'hFFFF in every PULSE.
  - Only the row field increments, wrapping 7→0; the bank field is ignored.
  - len still counts rows.
- `CIM_WL_BCAST_EN` undefined:
  - The bcast inputs are ignored (treated as 0).
  - The block contains no broadcast logic.

## Test plan
- Single burst: port 0, addr=7'h0E, len=2, PW=2, GAP=1, handshake at edge 0.
  - cs=16'h0002, wa0=8'h40 in cycles 2-3.
  - wa0=8'h80 in cycles 5-6.
  - cs=16'h0004, wa0=8'h01 in cycles 8-9.
  - done in cycle 11.
- Address wrap: addr=7'h7F, len=1.
  - Pulse 1 has cs=16'h8000, wa0=8'h80.
  - Pulse 2 has cs=16'h0001, wa0=8'h01.
- Arbitration: both ports valid continuously from reset.
  - Grants alternate 0,1,0,1.
  - Each ready rises only in IDLE.
- Abort: abort pulsed in the second cycle of pulse 1 of a 4-row burst.
  - Pulse 1 completes full width, then GAP, then done.
  - No pulse 2.
- Reset mid-burst: rst_n low during PULSE.
  - cs and wa0 go to 0 without a clock edge.
  - After release: IDLE, ready high, no done.
- Broadcast with `CIM_WL_BCAST_EN`: addr=7'h25, len=2, bcast=1.
  - cs=16'hFFFF every pulse.
  - wa0 sequence 8'h20, 8'h40, 8'h80.
  - With the macro undefined, the same stimulus gives cs=16'h0010, 16'h0010, 16'h0010 (addresses 0x25-0x27, bank 4).
